// File: rtl/ondra_pkg.sv
// Shared types and parameter defaults for the Ondra parallel-port write bridge.
package ondra_pkg;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_NUM_DEV     = 2;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_WR_PULSE    = 4;
   localparam int DEF_GAP         = 2;
   localparam int SEL_W           = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/ondra_sync_fifo.sv
// Single-clock capture FIFO with first-word fall-through read and occupancy count.
module ondra_sync_fifo #(
   parameter  int WIDTH = 11,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // NOTE: storage is not reset; the pointers and level decide what is valid, so clearing them flushes the FIFO.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers are exactly log2(DEPTH) bits wide, so increments wrap on their own.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (level == LVL_W'(DEPTH));
   assign empty    = (level == '0);

endmodule

// File: rtl/ondra_pport_bridge.sv
// Captures CPU parallel-port writes on strobe fall and replays them as timed
// active-low write strobes to slow devices paced by dev_ce_i.
module ondra_pport_bridge
   import ondra_pkg::*;
#(
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int NUM_DEV     = DEF_NUM_DEV,
   parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter  int WR_PULSE    = DEF_WR_PULSE,
   parameter  int GAP         = DEF_GAP,
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [DATA_W-1:0]  pd_i,
   input  logic [SEL_W-1:0]   dev_sel_i,
   input  logic               stb_n_i,
   input  logic               dev_ce_i,
   input  logic               clr_err_i,
   output logic [DATA_W-1:0]  dev_data_o,
   output logic [NUM_DEV-1:0] dev_wr_n_o,
   output logic               dev_en_o,
   output logic [LVL_W-1:0]   level_o,
   output logic               busy_o,
   output logic               ovf_o,
   output logic               sel_err_o
);

   localparam int CNT_MAX = (WR_PULSE > GAP) ? WR_PULSE : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [SEL_W:0] NUM_DEV_L = (SEL_W + 1)'(NUM_DEV);

   logic [SYNC_STAGES-1:0]  stb_sync;
   logic [SYNC_STAGES-1:0]  arm_sh;
   logic                    stb_prev;
   logic                    armed;
   logic                    stb_fall;
   logic                    sel_ok;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [DATA_W+SEL_W-1:0] fifo_rd;
   state_t                  state;
   logic [SEL_W-1:0]        cur_sel;
   logic [CNT_W-1:0]        cnt;
   logic [NUM_DEV-1:0]      wr_onehot;

   // Edges are accepted only after the synchroniser has seen a genuine high
   // strobe since reset, so a strobe already low at reset release is ignored.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         stb_sync <= '1;
         stb_prev <= 1'b1;
         arm_sh   <= '0;
         armed    <= 1'b0;
      end else begin
         stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb_n_i};
         stb_prev <= stb_sync[SYNC_STAGES-1];
         arm_sh   <= {arm_sh[SYNC_STAGES-2:0], 1'b1};
         if (arm_sh[SYNC_STAGES-1] && stb_sync[SYNC_STAGES-1]) armed <= 1'b1;
      end
   end

   assign stb_fall  = armed && stb_prev && !stb_sync[SYNC_STAGES-1];
   assign sel_ok    = ({1'b0, dev_sel_i} < NUM_DEV_L);
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign fifo_push = stb_fall && sel_ok && (!fifo_full || fifo_pop);

   ondra_sync_fifo #(
      .WIDTH (DATA_W + SEL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data ({dev_sel_i, pd_i}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level_o)
   );

   // NOTE: every combinational output gets a default before the loop so no latch is inferred.
   always_comb begin
      wr_onehot = '0;
      for (int i = 0; i < NUM_DEV; i++) wr_onehot[i] = (cur_sel == SEL_W'(i));
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         dev_data_o <= '0;
         cur_sel    <= '0;
         cnt        <= '0;
         dev_wr_n_o <= '1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state      <= ST_SETUP;
                  dev_data_o <= fifo_rd[DATA_W-1:0];
                  cur_sel    <= fifo_rd[DATA_W +: SEL_W];
               end
            end
            ST_SETUP: begin
               state      <= ST_STROBE;
               cnt        <= '0;
               dev_wr_n_o <= ~wr_onehot;
            end
            ST_STROBE: begin
               if (dev_ce_i) begin
                  if (cnt == CNT_W'(WR_PULSE - 1)) begin
                     state      <= ST_HOLD;
                     cnt        <= '0;
                     dev_wr_n_o <= '1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (dev_ce_i) begin
                  if (cnt == CNT_W'(GAP - 1)) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               dev_wr_n_o <= '1;
            end
         endcase
      end
   end

   // A new error in the same cycle as clr_err_i wins, keeping the flag set.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         dev_en_o  <= 1'b0;
         ovf_o     <= 1'b0;
         sel_err_o <= 1'b0;
      end else begin
         if (fifo_push) dev_en_o <= 1'b1;
         if (stb_fall && sel_ok && fifo_full && !fifo_pop) ovf_o <= 1'b1;
         else if (clr_err_i)                               ovf_o <= 1'b0;
         if (stb_fall && !sel_ok) sel_err_o <= 1'b1;
         else if (clr_err_i)      sel_err_o <= 1'b0;
      end
   end

   assign busy_o = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ondra_pport_bridge.sv
// Directed bench for ondra_pport_bridge at default parameters.
module tb_ondra_pport_bridge;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [7:0] pd_i;
   logic [2:0] dev_sel_i;
   logic       stb_n_i;
   logic       dev_ce_i;
   logic       clr_err_i;
   logic [7:0] dev_data_o;
   logic [1:0] dev_wr_n_o;
   logic       dev_en_o;
   logic [2:0] level_o;
   logic       busy_o;
   logic       ovf_o;
   logic       sel_err_o;

   int n_cmp = 0;
   int n_err = 0;

   int ce_period = 1;
   int ce_phase  = 0;

   int         wr_count  = 0;
   int         last_len  = 0;
   int         last_gap  = 0;
   int         multi_low = 0;
   logic [9:0] log_q [$];

   ondra_pport_bridge dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .pd_i       (pd_i),
      .dev_sel_i  (dev_sel_i),
      .stb_n_i    (stb_n_i),
      .dev_ce_i   (dev_ce_i),
      .clr_err_i  (clr_err_i),
      .dev_data_o (dev_data_o),
      .dev_wr_n_o (dev_wr_n_o),
      .dev_en_o   (dev_en_o),
      .level_o    (level_o),
      .busy_o     (busy_o),
      .ovf_o      (ovf_o),
      .sel_err_o  (sel_err_o)
   );

   initial forever #5 clk_sys = ~clk_sys;

   // Device clock enable: every cycle when ce_period is 1, else one pulse per period.
   initial begin
      dev_ce_i = 1'b1;
      forever begin
         @(negedge clk_sys);
         ce_phase++;
         dev_ce_i = ((ce_phase % ce_period) == 0);
      end
   end

   // Write-strobe monitor: logs {wr_n, data} at each pulse start, pulse length and preceding gap.
   initial begin
      logic [1:0] prev;
      int len;
      int gap;
      prev = 2'b11;
      len  = 0;
      gap  = 0;
      forever begin
         @(negedge clk_sys);
         if (dev_wr_n_o != 2'b11) begin
            if (prev == 2'b11) begin
               wr_count++;
               log_q.push_back({dev_wr_n_o, dev_data_o});
               last_gap = gap;
            end
            if (dev_wr_n_o != 2'b01 && dev_wr_n_o != 2'b10) multi_low++;
            len++;
            gap = 0;
         end else begin
            if (prev != 2'b11) last_len = len;
            len = 0;
            gap++;
         end
         prev = dev_wr_n_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host write: data and select held until the next call, so low+high >= 4 keeps them stable long enough.
   task automatic strobe(input logic [2:0] sel, input logic [7:0] data, input int low, input int high);
      @(negedge clk_sys);
      pd_i      = data;
      dev_sel_i = sel;
      stb_n_i   = 1'b0;
      repeat (low) @(negedge clk_sys);
      stb_n_i = 1'b1;
      repeat (high) @(negedge clk_sys);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while ((busy_o || dev_wr_n_o != 2'b11) && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic pulse_clr();
      @(negedge clk_sys);
      clr_err_i = 1'b1;
      @(negedge clk_sys);
      clr_err_i = 1'b0;
      @(negedge clk_sys);
   endtask

   initial begin
      int         base;
      int         n;
      int         held;
      logic [9:0] exp;

      reset_n   = 1'b0;
      stb_n_i   = 1'b1;
      pd_i      = '0;
      dev_sel_i = '0;
      clr_err_i = 1'b0;

      // Reset state
      repeat (4) @(negedge clk_sys);
      check("rst_wr_n",    32'(dev_wr_n_o), 32'h3);
      check("rst_level",   32'(level_o),    32'd0);
      check("rst_data",    32'(dev_data_o), 32'h00);
      check("rst_en",      32'(dev_en_o),   32'd0);
      check("rst_busy",    32'(busy_o),     32'd0);
      check("rst_ovf",     32'(ovf_o),      32'd0);
      check("rst_sel_err", 32'(sel_err_o),  32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);

      // Single write, dev_ce_i tied high
      base = wr_count;
      strobe(3'd1, 8'h9F, 3, 3);
      wait_idle(200, "single_idle");
      check("single_count", 32'(wr_count - base), 32'd1);
      check("single_pulse", 32'(log_q[base]),     32'h19F);
      check("single_len",   32'(last_len),        32'd4);
      check("single_data",  32'(dev_data_o),      32'h9F);
      check("single_en",    32'(dev_en_o),        32'd1);

      // Back-to-back entries: gap = HOLD(2) + IDLE(1) + SETUP(1)
      base = wr_count;
      strobe(3'd0, 8'h5A, 2, 2);
      strobe(3'd1, 8'hC3, 2, 2);
      wait_idle(200, "b2b_idle");
      check("b2b_count",  32'(wr_count - base), 32'd2);
      check("b2b_first",  32'(log_q[base]),     32'h25A);
      check("b2b_second", 32'(log_q[base + 1]), 32'h1C3);
      check("b2b_gap",    32'(last_gap),        32'd4);
      check("b2b_len",    32'(last_len),        32'd4);

      // Out-of-range select
      base = wr_count;
      strobe(3'd3, 8'h77, 2, 6);
      check("selerr_flag",  32'(sel_err_o),       32'd1);
      check("selerr_level", 32'(level_o),         32'd0);
      check("selerr_busy",  32'(busy_o),          32'd0);
      check("selerr_nowr",  32'(wr_count - base), 32'd0);
      pulse_clr();
      check("selerr_clr",   32'(sel_err_o),       32'd0);

      // Clear coinciding with a new select error: the error wins
      @(negedge clk_sys);
      pd_i      = 8'h66;
      dev_sel_i = 3'd3;
      stb_n_i   = 1'b0;
      @(negedge clk_sys);
      @(negedge clk_sys);
      clr_err_i = 1'b1;
      @(negedge clk_sys);
      clr_err_i = 1'b0;
      stb_n_i   = 1'b1;
      check("clr_vs_set", 32'(sel_err_o), 32'd1);
      pulse_clr();
      check("clr_after",  32'(sel_err_o), 32'd0);

      // Burst of six into a depth-4 FIFO with a slow device clock
      ce_period = 32;
      base = wr_count;
      for (int i = 0; i < 6; i++) strobe(3'(i % 2), 8'hA0 + 8'(i), 2, 2);
      repeat (4) @(negedge clk_sys);
      check("burst_ovf",   32'(ovf_o),   32'd1);
      check("burst_level", 32'(level_o), 32'd4);
      check("burst_busy",  32'(busy_o),  32'd1);
      wait_idle(3000, "burst_idle");
      check("burst_count", 32'(wr_count - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         exp = {((i % 2) == 0) ? 2'b10 : 2'b01, 8'hA0 + 8'(i)};
         check($sformatf("burst_wr%0d", i), 32'(log_q[base + i]), 32'(exp));
      end
      pulse_clr();
      check("ovf_clr", 32'(ovf_o), 32'd0);

      // Device clock every 4th cycle; strobe held low for 200 cycles
      ce_period = 4;
      base = wr_count;
      strobe(3'd0, 8'h3C, 200, 4);
      wait_idle(400, "slow_idle");
      check("slow_count", 32'(wr_count - base),                  32'd1);
      check("slow_pulse", 32'(log_q[base]),                      32'h23C);
      check("slow_len",   32'(last_len >= 13 && last_len <= 16), 32'd1);

      // Reset while a write is being strobed, with one entry queued
      base = wr_count;
      strobe(3'd0, 8'h11, 2, 2);
      strobe(3'd1, 8'h22, 2, 2);
      n = 0;
      while (dev_wr_n_o == 2'b11 && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      check("rstmid_in_strobe", 32'(dev_wr_n_o), 32'h2);
      check("rstmid_level_pre", 32'(level_o),    32'd1);
      held = wr_count;
      reset_n = 1'b0;
      @(negedge clk_sys);
      check("rstmid_wr_n",  32'(dev_wr_n_o), 32'h3);
      check("rstmid_level", 32'(level_o),    32'd0);
      check("rstmid_en",    32'(dev_en_o),   32'd0);
      check("rstmid_busy",  32'(busy_o),     32'd0);

      // Strobe falls while reset is held and stays low past release
      stb_n_i = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_sys);
      stb_n_i = 1'b1;
      repeat (300) @(negedge clk_sys);
      check("rstmid_no_more_wr", 32'(wr_count - held), 32'd0);
      check("rstlow_no_capture", 32'(level_o),         32'd0);
      check("rstlow_en",         32'(dev_en_o),        32'd0);
      check("one_hot_low",       32'(multi_low),       32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
